// File: rtl/one_eight_demux_if.sv
// Bundle for the 1-to-8 demux: single-bit input stream in, 8-lane word out.
interface one_eight_demux_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [2:0] select;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e;
  logic       f;
  logic       g;
  logic       h;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] slot;

  // Producer/consumer side that drives the stream and drains the word.
  modport master (
    output in_bit, in_valid, mode, select, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, slot
  );

  // Demux side.
  modport slave (
    input  in_bit, in_valid, mode, select, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, slot
  );
endinterface

// File: rtl/one_eight_demux.sv
// Registered 1-to-8 demultiplexer: collects bits into lanes a..h (addressed
// by select or by a wrapping slot counter) and presents the completed word
// with a valid/ready handshake.
module one_eight_demux (
  input  logic                clk,
  input  logic                rst_n,
  one_eight_demux_if.slave    bus
);

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [LANES-1:0]   lanes_q, lanes_d;
  logic [LANES-1:0]   filled_q, filled_d;
  logic [SEL_W-1:0]   slot_q, slot_d;
  logic [SEL_W-1:0]   tgt_c;

  // State, lane, write-mask and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      lanes_q  <= '0;
      filled_q <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      filled_q <= filled_d;
      slot_q   <= slot_d;
    end
  end

  // Next-state: accept a bit while filling, release the word on drain.
  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    filled_d = filled_q;
    slot_d   = slot_q;
    tgt_c    = bus.mode ? slot_q : bus.select;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          lanes_d[tgt_c]  = bus.in_bit;
          filled_d[tgt_c] = 1'b1;
          if (bus.mode) begin
            slot_d = slot_q + SEL_W'(1);
          end
          if (filled_d == {LANES{1'b1}}) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d  = FILL;
          filled_d = '0;
          slot_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs are direct decodes of registered state.
  assign bus.a         = lanes_q[0];
  assign bus.b         = lanes_q[1];
  assign bus.c         = lanes_q[2];
  assign bus.d         = lanes_q[3];
  assign bus.e         = lanes_q[4];
  assign bus.f         = lanes_q[5];
  assign bus.g         = lanes_q[6];
  assign bus.h         = lanes_q[7];
  assign bus.slot      = slot_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = (state_q == FILL);

endmodule

// File: tb/tb_one_eight_demux.sv
// Self-checking bench for one_eight_demux: directed scenarios plus random
// traffic compared against a lane-array reference model.
module tb_one_eight_demux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  one_eight_demux_if bus();

  one_eight_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: lane values, which lanes were written, slot, word held.
  bit m_lane [8];
  bit m_set  [8];
  int m_slot;
  bit m_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] dut_word();
    return {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  endfunction

  function automatic logic [7:0] model_word();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = m_lane[i];
    return w;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_lane[i] = 1'b0;
      m_set[i]  = 1'b0;
    end
    m_slot = 0;
    m_full = 1'b0;
  endfunction

  // One rising edge as seen by the model, using currently driven inputs.
  function automatic void model_edge();
    int  lane;
    bit  all;
    if (!m_full) begin
      if (bus.in_valid) begin
        lane = bus.mode ? m_slot : int'(bus.select);
        m_lane[lane] = bus.in_bit;
        m_set[lane]  = 1'b1;
        if (bus.mode) m_slot = (m_slot + 1) % 8;
        all = 1'b1;
        for (int i = 0; i < 8; i++) if (!m_set[i]) all = 1'b0;
        if (all) m_full = 1'b1;
      end
    end else if (bus.out_ready) begin
      m_full = 1'b0;
      for (int i = 0; i < 8; i++) m_set[i] = 1'b0;
      m_slot = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".lanes"},     32'(dut_word()),     32'(model_word()));
    check({tag, ".out_valid"}, 32'(bus.out_valid),  32'(m_full));
    check({tag, ".in_ready"},  32'(bus.in_ready),   32'(!m_full));
    check({tag, ".slot"},      32'(bus.slot),       32'(m_slot));
  endtask

  task automatic drive(input bit v, input bit b, input bit md, input bit [2:0] sel, input bit ordy);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.mode      = md;
    bus.select    = sel;
    bus.out_ready = ordy;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step("drain");
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    step("post_drain");
  endtask

  bit       seq_bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  bit [2:0] adr_sel  [9] = '{7, 0, 3, 3, 1, 2, 4, 5, 6};
  bit       adr_bit  [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 1};

  initial begin
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    check_all("reset");
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Sequential fill
    for (int i = 0; i < 8; i++) begin
      check("seq.slot_before", 32'(bus.slot), 32'(i));
      drive(1'b1, seq_bits[i], 1'b1, 3'($urandom), 1'b0);
      step("seq");
    end
    check("seq.word",      32'(dut_word()),    32'h4D);
    check("seq.out_valid", 32'(bus.out_valid), 32'd1);
    check("seq.in_ready",  32'(bus.in_ready),  32'd0);

    // Backpressure hold
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'(i % 2), 1'b1, 3'($urandom), 1'b0);
      step("hold");
      check("hold.word", 32'(dut_word()), 32'h4D);
    end
    drain();
    check("bp.in_ready", 32'(bus.in_ready), 32'd1);
    check("bp.slot",     32'(bus.slot),     32'd0);
    check("bp.word",     32'(dut_word()),   32'h4D);

    // Addressed with duplicates
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, adr_bit[i], 1'b0, adr_sel[i], 1'b0);
      step("addr");
      if (i == 7) check("addr.valid_after8", 32'(bus.out_valid), 32'd0);
    end
    check("addr.valid_after9", 32'(bus.out_valid), 32'd1);
    check("addr.word",         32'(dut_word()),    32'hD5);
    drain();

    // Gapped input
    for (int i = 0; i < 16; i++) begin
      drive(1'((i % 2) == 0), 1'b1, 1'b1, 3'($urandom), 1'b0);
      step("gap");
    end
    check("gap.out_valid", 32'(bus.out_valid), 32'd1);
    check("gap.word",      32'(dut_word()),    32'hFF);
    drain();

    // Reset mid-group
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      step("pre_rst");
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.word", 32'(dut_word()), 32'h00);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      step("post_rst");
      if (i == 6) check("post_rst.valid_after7", 32'(bus.out_valid), 32'd0);
    end
    check("post_rst.valid_after8", 32'(bus.out_valid), 32'd1);
    drain();

    // Mixed mode
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      step("mix_seq");
    end
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'(i), 1'b0);
      step("mix_adr");
      check("mix.slot_frozen", 32'(bus.slot), 32'd4);
    end
    check("mix.out_valid", 32'(bus.out_valid), 32'd1);
    check("mix.word",      32'(dut_word()),    32'h0F);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom_range(0, 2) == 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
